i2c_target: RTL

I2C target (slave) responder for the bus driven by the team's I2C master: it watches SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs, and then receives write bytes or transmits read bytes. It drives the bus only through open-drain enables and sits between the board-level I2C pins and a simple byte-stream register or FIFO client.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 38 +++
 rtl/i2c_target.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared state encoding and bus constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  localparam logic       ACK_BIT   = 1'b0;
  localparam logic       NACK_BIT  = 1'b1;
  localparam logic [7:0] IDLE_FILL = 8'hFF;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one open-drain bus line, with registered-edge detect.
// Flops reset to 1 so a released (idle) bus is assumed until the pin says otherwise.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next values of the synchronizer chain and the edge-detect flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: START/STOP detect, 7-bit address match, byte write and read via open-drain enables.
// Define I2C_TARGET_CLK_STRETCH_EN to hold SCL low while no read byte is available.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

`ifdef I2C_TARGET_CLK_STRETCH_EN
  localparam logic STRETCH_EN = 1'b1;
`else
  localparam logic STRETCH_EN = 1'b0;
`endif

  // Lines must be seen high for longer than the sync pipeline before START is trusted.
  localparam int ARM_CYCLES = SYNC_STAGES + 2;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det, armed, addr_hit, load_tx, release_scl;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             ack_ph_q, ack_ph_d;
  logic [7:0]       shift_q, shift_d;
  logic             rw_q, rw_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             sda_oe_q, sda_oe_d;
  logic             scl_oe_q, scl_oe_d;
  logic             wait_tx_q, wait_tx_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst_n(rst_n), .line_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst_n(rst_n), .line_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign armed     = (arm_cnt_q == ARM_W'(ARM_CYCLES));
  assign start_det = sda_fall & scl_lvl & armed;
  assign stop_det  = sda_rise & scl_lvl;
  assign addr_hit  = (shift_q[6:0] == ADDR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; STOP outranks START, and both outrank any bit event.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q == 3'd7) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
          else                               state_d = ST_ADDR;
        end
        ST_ADDR_ACK: begin
          if (scl_fall && ack_ph_q) state_d = rw_q ? ST_RD_DATA : ST_WR_DATA;
          else                      state_d = ST_ADDR_ACK;
        end
        ST_WR_DATA: begin
          if (scl_rise && bit_cnt_q == 3'd7) state_d = ST_WR_ACK;
          else                               state_d = ST_WR_DATA;
        end
        ST_WR_ACK: begin
          if (scl_fall && ack_ph_q) state_d = ST_WR_DATA;
          else                      state_d = ST_WR_ACK;
        end
        ST_RD_DATA: begin
          if (scl_rise && bit_cnt_q == 3'd7) state_d = ST_RD_ACK;
          else                               state_d = ST_RD_DATA;
        end
        ST_RD_ACK: begin
          if (scl_rise && ack_ph_q && sda_lvl == NACK_BIT) state_d = ST_IGNORE;
          else if (scl_fall && ack_ph_q)                   state_d = ST_RD_DATA;
          else                                             state_d = ST_RD_ACK;
        end
        ST_IDLE:   state_d = ST_IDLE;
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath logic. ack_ph marks the second half of a 9th-bit slot.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    ack_ph_d    = ack_ph_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    tx_sh_d     = tx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ready_d  = 1'b0;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    wait_tx_d   = wait_tx_q;
    load_tx     = 1'b0;
    release_scl = 1'b0;

    if (armed)                   arm_cnt_d = arm_cnt_q;
    else if (scl_lvl && sda_lvl) arm_cnt_d = arm_cnt_q + ARM_W'(1);
    else                         arm_cnt_d = '0;

    if (stop_det || start_det) begin
      busy_d    = ~stop_det;
      sda_oe_d  = 1'b0;
      wait_tx_d = 1'b0;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 3'd1;
            ack_ph_d  = 1'b0;
            if (bit_cnt_q == 3'd7 && state_q == ST_ADDR) begin
              rw_d = sda_lvl;
            end else if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_lvl};
              rx_valid_d = 1'b1;
            end else begin
              rw_d = rw_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall && !ack_ph_q) begin
            sda_oe_d = ~ACK_BIT;
            ack_ph_d = 1'b1;
          end else if (scl_fall) begin
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd0;
            load_tx   = (state_q == ST_ADDR_ACK) && rw_q;
          end else begin
            ack_ph_d = ack_ph_q;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            ack_ph_d  = 1'b0;
          end else if (scl_fall && bit_cnt_q != 3'd0) begin
            tx_sh_d  = {tx_sh_q[6:0], 1'b1};
            sda_oe_d = ~tx_sh_q[6];
          end else begin
            tx_sh_d = tx_sh_q;
          end
        end
        ST_RD_ACK: begin
          if (scl_fall && !ack_ph_q) begin
            sda_oe_d = 1'b0;
            ack_ph_d = 1'b1;
          end else if (scl_fall) begin
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd0;
            load_tx   = 1'b1;
          end else begin
            ack_ph_d = ack_ph_q;
          end
        end
        default: begin
          bit_cnt_d = bit_cnt_q;
        end
      endcase

      if (load_tx && tx_valid) begin
        tx_sh_d    = tx_data;
        tx_ready_d = 1'b1;
        sda_oe_d   = ~tx_data[7];
      end else if (load_tx && STRETCH_EN) begin
        wait_tx_d = 1'b1;
        sda_oe_d  = 1'b0;
      end else if (load_tx) begin
        tx_sh_d  = IDLE_FILL;
        sda_oe_d = ~IDLE_FILL[7];
      end else if (wait_tx_q && tx_valid) begin
        // Data goes out now; SCL is let go one cycle later so SDA is settled first.
        tx_sh_d     = tx_data;
        tx_ready_d  = 1'b1;
        sda_oe_d    = ~tx_data[7];
        wait_tx_d   = 1'b0;
        release_scl = 1'b1;
      end else begin
        wait_tx_d = wait_tx_q;
      end
    end

    scl_oe_d = STRETCH_EN & (wait_tx_d | release_scl);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= 3'd0;
      ack_ph_q   <= 1'b0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      tx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      wait_tx_q  <= 1'b0;
      arm_cnt_q  <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      ack_ph_q   <= ack_ph_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      tx_sh_q    <= tx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      wait_tx_q  <= wait_tx_d;
      arm_cnt_q  <= arm_cnt_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign scl_oe   = scl_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule
